// File: rtl/fold_lut_writer.sv
// Builds the 16-entry nibble-fold table T[k] = k * (2^shift mod Q) mod Q and
// streams it out over a one-write-per-cycle RAM port.
//
// state | meaning
// IDLE  | waiting for start; shift sampled with start
// BASE  | modular doubling, shift+1 cycles, yields 2^shift mod Q
// FILL  | one write per cycle, addresses 0..15
// DONE  | one-cycle done pulse, then back to IDLE
module fold_lut_writer #(
  parameter int Q      = 3329,
  parameter int DATA_W = 12,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4:0]        shift,
  output logic              busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] base,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, BASE, FILL, DONE} state_t;

  localparam logic [DATA_W:0] Q_W = Q[DATA_W:0];

  state_t            state_q, state_d;
  logic [4:0]        shift_q, shift_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] r_q, r_d;
  logic [DATA_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic [DATA_W:0] dbl, dbl_mod, sum, sum_mod;

  // Both operands are already reduced, so one conditional subtract is exact.
  always_comb begin
    dbl     = {r_q, 1'b0};
    dbl_mod = (dbl >= Q_W) ? dbl - Q_W : dbl;
    sum     = {1'b0, acc_q} + {1'b0, base_q};
    sum_mod = (sum >= Q_W) ? sum - Q_W : sum;
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    base_d  = base_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = shift;
          r_d     = DATA_W'(1);
          cnt_d   = '0;
          state_d = BASE;
        end
      end
      BASE: begin
        if (cnt_q == shift_q) begin
          base_d  = r_q;
          acc_d   = '0;
          idx_d   = '0;
          state_d = FILL;
        end else begin
          r_d   = dbl_mod[DATA_W-1:0];
          cnt_d = cnt_q + 5'd1;
        end
      end
      FILL: begin
        acc_d = sum_mod[DATA_W-1:0];
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == {ADDR_W{1'b1}}) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
      base_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs decode registered state only, so they are stable for the whole cycle.
  assign busy    = (state_q != IDLE);
  assign wr_en   = (state_q == FILL);
  assign wr_addr = wr_en ? idx_q : '0;
  assign wr_data = wr_en ? acc_q : '0;
  assign base    = base_q;
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_fold_lut_writer.sv
// Randomized bench for fold_lut_writer: a cycle-offset reference model checked
// every cycle, plus directed builds with hand-computed table values.
module tb_fold_lut_writer;
  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  shift;
  logic        busy, wr_en, done;
  logic [3:0]  wr_addr;
  logic [11:0] wr_data, base;

  fold_lut_writer #(.Q(Q), .DATA_W(12), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .shift(shift),
    .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .base(base), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pow_mod(input int s);
    int v = 1;
    for (int i = 0; i < s; i++) v = (v * 2) % Q;
    return v;
  endfunction

  // Reference model: a build is just an offset d from its sampling edge.
  int cyc = 0;
  bit m_active = 0;
  int m_d = 0, m_s = 0, m_b = 0, m_base = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_d = 0; m_base = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_d = 0; m_s = int'(shift); m_b = pow_mod(int'(shift));
      end
    end else begin
      m_d++;
      if (m_d == m_s + 1) m_base = m_b;
      if (m_d == m_s + 18) m_active = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      bit e_wr;
      int k;
      e_wr = m_active && m_d >= m_s + 1 && m_d <= m_s + 16;
      k = m_d - m_s - 1;
      chk("busy", int'(busy), int'(m_active));
      chk("wr_en", int'(wr_en), int'(e_wr));
      chk("done", int'(done), int'(m_active && m_d == m_s + 17));
      chk("base", int'(base), m_base);
      if (e_wr) begin
        chk("wr_addr", int'(wr_addr), k);
        chk("wr_data", int'(wr_data), (k * m_b) % Q);
      end
    end
  end

  // Write sink and per-build observations.
  int ram[16];
  int nw, ndone, first_d, done_d, idle_d;

  task automatic run_build(input int sh, input bit poke);
    int c0, d, b;
    bit fin, poked;
    for (int k = 0; k < 16; k++) ram[k] = -1;
    nw = 0; ndone = 0; first_d = -1; done_d = -1; idle_d = -1;
    fin = 0; poked = 0;
    start = 1'b1; shift = 5'(sh);
    @(negedge clk);
    c0 = cyc;
    for (int i = 0; i < 60 && !fin; i++) begin
      start = 1'b0;
      if (i == 0) shift = 5'($urandom_range(0, 31));
      d = cyc - c0;
      if (wr_en) begin
        if (first_d < 0) first_d = d;
        chk("addr_order", int'(wr_addr), nw);
        ram[wr_addr] = int'(wr_data);
        nw++;
      end
      if (done) begin ndone++; done_d = d; end
      if (!busy && d > 0) begin idle_d = d; fin = 1; end
      if (poke && !poked && nw == 6) begin start = 1'b1; poked = 1; end
      if (!fin) @(negedge clk);
    end
    if (!fin) chk("build_timeout", 0, 1);
    b = pow_mod(sh);
    chk("lat_first_wr", first_d, sh + 1);
    chk("lat_done", done_d, sh + 17);
    chk("lat_idle", idle_d, sh + 18);
    chk("write_count", nw, 16);
    chk("done_pulses", ndone, 1);
    for (int k = 0; k < 16; k++) begin
      chk("entry", ram[k], (k * b) % Q);
      chk("entry_range", int'(ram[k] >= 0 && ram[k] < Q), 1);
    end
  endtask

  int lit12[16] = '{0, 767, 1534, 2301, 3068, 506, 1273, 2040,
                    2807, 245, 1012, 1779, 2546, 3313, 751, 1518};

  initial begin
    rst_n = 1'b0; start = 1'b0; shift = 5'd0;
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_base", int'(base), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_build(12, 0);
    chk("s12_base", int'(base), 767);
    chk("s12_first", first_d, 13);
    chk("s12_done", done_d, 29);
    for (int k = 0; k < 16; k++) chk("s12_lit", ram[k], lit12[k]);

    run_build(0, 0);
    chk("s0_base", int'(base), 1);
    chk("s0_done", done_d, 17);
    chk("s0_idle", idle_d, 18);
    for (int k = 0; k < 16; k++) chk("s0_lit", ram[k], k);

    run_build(16, 0);
    chk("s16_base", int'(base), 2285);
    chk("s16_w1", ram[1], 2285);
    chk("s16_w2", ram[2], 1241);
    chk("s16_w3", ram[3], 197);
    run_build(20, 0);
    chk("s20_base", int'(base), 3270);
    chk("s20_w1", ram[1], 3270);
    chk("s20_w2", ram[2], 3211);

    repeat (3) @(negedge clk);
    run_build(12, 1);

    // Asynchronous reset in the middle of FILL.
    start = 1'b1; shift = 5'd12;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 40 && !(wr_en && wr_addr == 4'd7); i++) @(negedge clk);
    chk("reached_k7", int'(wr_en && wr_addr == 4'd7), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr_en", int'(wr_en), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_base", int'(base), 0);
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_idle", int'(busy), 0);

    for (int n = 0; n < 50; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_build(int'($urandom_range(0, 31)), bit'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
